// File: rtl/mmc1_serial_mapper_if.sv
// mmc1_serial_mapper_if
// Bundles the CPU-side write/decode signals, the PPU address bits and the
// mapped bank outputs of the MMC1-style serial mapper.
//   cpu_wr        write strobe for $8000-$FFFF (one cycle)
//   cpu_a         CPU A14:A13 captured with the strobe
//   cpu_d7        shift reset bit
//   cpu_d0        serial data bit
//   cpu_a14       live CPU A14 for PRG windowing
//   cpu_wram_sel  live decode of $6000-$7FFF
//   ppu_a         PPU A12:A10
//   prg_bank      16 KiB PRG bank number
//   chr_bank      4 KiB CHR bank number
//   ciram_a10     nametable RAM A10
//   wram_ce_n     WRAM chip enable, active low
//   shift_busy    a partial serial word is pending
// The master modport belongs to the bus side, the slave modport to the mapper.
interface mmc1_serial_mapper_if #(
    parameter int PRG_W = 4,
    parameter int CHR_W = 5
);
    logic             cpu_wr;
    logic [1:0]       cpu_a;
    logic             cpu_d7;
    logic             cpu_d0;
    logic             cpu_a14;
    logic             cpu_wram_sel;
    logic [2:0]       ppu_a;
    logic [PRG_W-1:0] prg_bank;
    logic [CHR_W-1:0] chr_bank;
    logic             ciram_a10;
    logic             wram_ce_n;
    logic             shift_busy;

    modport master (
        output cpu_wr, cpu_a, cpu_d7, cpu_d0, cpu_a14, cpu_wram_sel, ppu_a,
        input  prg_bank, chr_bank, ciram_a10, wram_ce_n, shift_busy
    );

    modport slave (
        input  cpu_wr, cpu_a, cpu_d7, cpu_d0, cpu_a14, cpu_wram_sel, ppu_a,
        output prg_bank, chr_bank, ciram_a10, wram_ce_n, shift_busy
    );
endinterface

// File: rtl/mmc1_serial_mapper.sv
// mmc1_serial_mapper
// MMC1-style mapper: CPU writes deliver one bit at a time into a shift
// register; the last bit of each word commits it to the control, CHR0, CHR1
// or PRG register selected by the address of that last write. Bank numbers,
// nametable mirroring and the WRAM enable are decoded combinationally from
// those registers and the live CPU/PPU address bits.
// Ports:
//   clk   system clock, one cycle per CPU bus cycle
//   nres  asynchronous active-low reset
//   bus   mmc1_serial_mapper_if.slave (CPU write path, address inputs,
//         bank/mirroring/WRAM outputs, shift_busy)
module mmc1_serial_mapper #(
    parameter int DATA_W        = 5,
    parameter int PRG_W         = 4,
    parameter int CHR_W         = 5,
    parameter int IGNORE_CONSEC = 1,
    parameter int WRAM_CTL      = 1
) (
    input logic                  clk,
    input logic                  nres,
    mmc1_serial_mapper_if.slave  bus
);

    localparam int                CNT_W      = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]  LAST_BIT   = CNT_W'(DATA_W - 1);
    localparam logic [DATA_W-1:0] CTRL_RESET = DATA_W'(12);
    localparam bit                IGN_EN     = (IGNORE_CONSEC != 0);
    localparam bit                WRAM_EN    = (WRAM_CTL != 0);

    logic [DATA_W-1:0] sr;
    logic [DATA_W-1:0] ctrl;
    logic [DATA_W-1:0] chr0;
    logic [DATA_W-1:0] chr1;
    logic [DATA_W-1:0] prg;
    logic [DATA_W-1:0] word;
    logic [CNT_W-1:0]  count;
    logic              wr_d1;
    logic              acc;
    logic              last_bit;

    logic [PRG_W-1:0]  prg_lo;
    logic [CHR_W-1:0]  chr0_lo;
    logic [CHR_W-1:0]  chr1_lo;
    logic [PRG_W-1:0]  prg_bank_c;
    logic [CHR_W-1:0]  chr_bank_c;
    logic              ciram_c;
    logic              a12;

    // Bits that are stored but never decoded (sr[0] always shifts out,
    // upper ctrl/bank bits beyond the field widths).
    logic              unused_bits;

    // A strobe immediately following another strobe is the second half of a
    // 6502 read-modify-write and is dropped when the filter is enabled.
    assign acc      = bus.cpu_wr & ~(IGN_EN & wr_d1);
    assign last_bit = (count == LAST_BIT);
    assign word     = {bus.cpu_d0, sr[DATA_W-1:1]};

    // Serial collection and register commit. A d7 reset write clears the
    // partial word, even when it lands on what would be the final bit.
    always_ff @(posedge clk or negedge nres) begin
        if (!nres) begin
            sr    <= '0;
            count <= '0;
            wr_d1 <= 1'b0;
            ctrl  <= CTRL_RESET;
            chr0  <= '0;
            chr1  <= '0;
            prg   <= '0;
        end else begin
            wr_d1 <= bus.cpu_wr;
            if (acc) begin
                if (bus.cpu_d7) begin
                    sr         <= '0;
                    count      <= '0;
                    ctrl[3:2]  <= 2'b11;
                end else if (last_bit) begin
                    sr    <= '0;
                    count <= '0;
                    case (bus.cpu_a)
                        2'd0:    ctrl <= word;
                        2'd1:    chr0 <= word;
                        2'd2:    chr1 <= word;
                        default: prg  <= word;
                    endcase
                end else begin
                    sr    <= word;
                    count <= count + CNT_W'(1);
                end
            end
        end
    end

    assign prg_lo  = prg[PRG_W-1:0];
    assign chr0_lo = chr0[CHR_W-1:0];
    assign chr1_lo = chr1[CHR_W-1:0];
    assign a12     = bus.ppu_a[2];

    // PRG windowing: 32 KiB mode replaces the bank LSB with A14; mode 2 fixes
    // the first window to bank 0; mode 3 fixes the second window to the last bank.
    always_comb begin
        prg_bank_c = '0;
        case (ctrl[3:2])
            2'b10:   prg_bank_c = bus.cpu_a14 ? prg_lo : '0;
            2'b11:   prg_bank_c = bus.cpu_a14 ? '1 : prg_lo;
            default: prg_bank_c = (prg_lo & ~PRG_W'(1)) | PRG_W'(bus.cpu_a14);
        endcase
    end

    // CHR windowing: 8 KiB mode pairs chr0 with A12 as the LSB, 4 KiB mode
    // picks chr0 or chr1 by A12.
    always_comb begin
        chr_bank_c = '0;
        if (ctrl[4])
            chr_bank_c = a12 ? chr1_lo : chr0_lo;
        else
            chr_bank_c = (chr0_lo & ~CHR_W'(1)) | CHR_W'(a12);
    end

    // Mirroring: single-screen low/high, vertical (A10), horizontal (A11).
    always_comb begin
        ciram_c = 1'b0;
        case (ctrl[1:0])
            2'd0:    ciram_c = 1'b0;
            2'd1:    ciram_c = 1'b1;
            2'd2:    ciram_c = bus.ppu_a[0];
            default: ciram_c = bus.ppu_a[1];
        endcase
    end

    assign bus.prg_bank   = prg_bank_c;
    assign bus.chr_bank   = chr_bank_c;
    assign bus.ciram_a10  = ciram_c;
    assign bus.wram_ce_n  = ~(bus.cpu_wram_sel & ~(WRAM_EN & prg[DATA_W-1]));
    assign bus.shift_busy = (count != '0);

    assign unused_bits = ^{sr[0], ctrl, chr0, chr1, prg};

endmodule

// File: tb/tb_mmc1_serial_mapper.sv
// tb_mmc1_serial_mapper
// Drives three mapper instances from one shared set of bus inputs:
//   dut0: defaults (5-bit words, write filter on, WRAM control on)
//   dut1: write filter off
//   dut2: 6-bit words
// A behavioural model per instance collects bits in a list and rebuilds the
// word arithmetically; every cycle all outputs are compared with it. A table
// of directed operations adds fixed expected values for dut0, and a few
// hand-written sequences cover the filter and the 6-bit WRAM control.
module tb_mmc1_serial_mapper;

    logic       clk = 1'b0;
    logic       nres;
    logic       cpu_wr;
    logic [1:0] cpu_a;
    logic       cpu_d7;
    logic       cpu_d0;
    logic       cpu_a14;
    logic       cpu_wram_sel;
    logic [2:0] ppu_a;

    always #5 clk = ~clk;

    mmc1_serial_mapper_if #(.PRG_W(4), .CHR_W(5)) bus0 ();
    mmc1_serial_mapper_if #(.PRG_W(4), .CHR_W(5)) bus1 ();
    mmc1_serial_mapper_if #(.PRG_W(4), .CHR_W(5)) bus2 ();

    assign bus0.cpu_wr = cpu_wr;  assign bus0.cpu_a = cpu_a;  assign bus0.cpu_d7 = cpu_d7;
    assign bus0.cpu_d0 = cpu_d0;  assign bus0.cpu_a14 = cpu_a14;
    assign bus0.cpu_wram_sel = cpu_wram_sel;  assign bus0.ppu_a = ppu_a;
    assign bus1.cpu_wr = cpu_wr;  assign bus1.cpu_a = cpu_a;  assign bus1.cpu_d7 = cpu_d7;
    assign bus1.cpu_d0 = cpu_d0;  assign bus1.cpu_a14 = cpu_a14;
    assign bus1.cpu_wram_sel = cpu_wram_sel;  assign bus1.ppu_a = ppu_a;
    assign bus2.cpu_wr = cpu_wr;  assign bus2.cpu_a = cpu_a;  assign bus2.cpu_d7 = cpu_d7;
    assign bus2.cpu_d0 = cpu_d0;  assign bus2.cpu_a14 = cpu_a14;
    assign bus2.cpu_wram_sel = cpu_wram_sel;  assign bus2.ppu_a = ppu_a;

    mmc1_serial_mapper #(.DATA_W(5), .PRG_W(4), .CHR_W(5), .IGNORE_CONSEC(1), .WRAM_CTL(1))
        dut0 (.clk(clk), .nres(nres), .bus(bus0));
    mmc1_serial_mapper #(.DATA_W(5), .PRG_W(4), .CHR_W(5), .IGNORE_CONSEC(0), .WRAM_CTL(1))
        dut1 (.clk(clk), .nres(nres), .bus(bus1));
    mmc1_serial_mapper #(.DATA_W(6), .PRG_W(4), .CHR_W(5), .IGNORE_CONSEC(1), .WRAM_CTL(1))
        dut2 (.clk(clk), .nres(nres), .bus(bus2));

    logic [3:0] o_prg   [3];
    logic [4:0] o_chr   [3];
    logic       o_ciram [3];
    logic       o_ce    [3];
    logic       o_busy  [3];

    assign o_prg[0] = bus0.prg_bank;  assign o_chr[0] = bus0.chr_bank;
    assign o_ciram[0] = bus0.ciram_a10;  assign o_ce[0] = bus0.wram_ce_n;
    assign o_busy[0] = bus0.shift_busy;
    assign o_prg[1] = bus1.prg_bank;  assign o_chr[1] = bus1.chr_bank;
    assign o_ciram[1] = bus1.ciram_a10;  assign o_ce[1] = bus1.wram_ce_n;
    assign o_busy[1] = bus1.shift_busy;
    assign o_prg[2] = bus2.prg_bank;  assign o_chr[2] = bus2.chr_bank;
    assign o_ciram[2] = bus2.ciram_a10;  assign o_ce[2] = bus2.wram_ce_n;
    assign o_busy[2] = bus2.shift_busy;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state, one slot per instance.
    int m_dw   [3] = '{5, 5, 6};
    int m_ign  [3] = '{1, 0, 1};
    int m_wctl [3] = '{1, 1, 1};
    int m_ctrl [3];
    int m_chr0 [3];
    int m_chr1 [3];
    int m_prg  [3];
    int m_bits [3][$];
    bit m_prev [3];

    typedef enum int {OP_WRITE, OP_PARTIAL, OP_RESETWR, OP_NRES, OP_CHECK} op_t;

    typedef struct {
        op_t op;
        int  addr;
        int  value;
        int  nbits;
        int  a14;
        int  sel;
        int  ppu;
        int  e_prg;
        int  e_chr;
        int  e_ciram;
        int  e_ce;
        int  e_busy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(op_t op, int addr, int value, int nbits, int a14, int sel,
                                int ppu, int e_prg, int e_chr, int e_ciram, int e_ce,
                                int e_busy);
        vec_t v;
        v.op = op;  v.addr = addr;  v.value = value;  v.nbits = nbits;
        v.a14 = a14;  v.sel = sel;  v.ppu = ppu;
        v.e_prg = e_prg;  v.e_chr = e_chr;  v.e_ciram = e_ciram;
        v.e_ce = e_ce;  v.e_busy = e_busy;
        return v;
    endfunction

    function automatic vec_t chk(int a14, int sel, int ppu, int e_prg, int e_chr,
                                 int e_ciram, int e_ce, int e_busy);
        return mk(OP_CHECK, 0, 0, 0, a14, sel, ppu, e_prg, e_chr, e_ciram, e_ce, e_busy);
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests_run++;
        if (actual != expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected,
                     $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_ctrl[k] = 12;
            m_chr0[k] = 0;
            m_chr1[k] = 0;
            m_prg[k]  = 0;
            m_bits[k].delete();
            m_prev[k] = 1'b0;
        end
    endtask

    function automatic int exp_prg(int k);
        int mode;
        int lo;
        mode = (m_ctrl[k] >> 2) & 3;
        lo   = m_prg[k] % 16;
        if (mode < 2)       return (lo & 14) + int'(cpu_a14);
        else if (mode == 2) return cpu_a14 ? lo : 0;
        else                return cpu_a14 ? 15 : lo;
    endfunction

    function automatic int exp_chr(int k);
        int a12;
        a12 = (int'(ppu_a) >> 2) & 1;
        if (((m_ctrl[k] >> 4) & 1) == 0) return (m_chr0[k] & 30) + a12;
        return (a12 != 0) ? (m_chr1[k] % 32) : (m_chr0[k] % 32);
    endfunction

    function automatic int exp_ciram(int k);
        case (m_ctrl[k] & 3)
            0:       return 0;
            1:       return 1;
            2:       return int'(ppu_a) & 1;
            default: return (int'(ppu_a) >> 1) & 1;
        endcase
    endfunction

    function automatic int exp_ce(int k);
        bit wdis;
        wdis = (m_wctl[k] != 0) && (((m_prg[k] >> (m_dw[k] - 1)) & 1) != 0);
        return (cpu_wram_sel && !wdis) ? 0 : 1;
    endfunction

    task automatic model_check_all();
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("dut%0d prg_bank", k), int'(o_prg[k]), exp_prg(k));
            checkOutput($sformatf("dut%0d chr_bank", k), int'(o_chr[k]), exp_chr(k));
            checkOutput($sformatf("dut%0d ciram_a10", k), int'(o_ciram[k]), exp_ciram(k));
            checkOutput($sformatf("dut%0d wram_ce_n", k), int'(o_ce[k]), exp_ce(k));
            checkOutput($sformatf("dut%0d shift_busy", k), int'(o_busy[k]),
                        (m_bits[k].size() != 0) ? 1 : 0);
        end
    endtask

    // Applies the current inputs at the coming clock edge.
    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            bit accepted;
            accepted  = cpu_wr && !((m_ign[k] != 0) && m_prev[k]);
            m_prev[k] = cpu_wr;
            if (accepted) begin
                if (cpu_d7) begin
                    m_bits[k].delete();
                    m_ctrl[k] = m_ctrl[k] | 12;
                end else begin
                    m_bits[k].push_back(int'(cpu_d0));
                    if (m_bits[k].size() == m_dw[k]) begin
                        int w;
                        w = 0;
                        for (int i = 0; i < m_dw[k]; i++) w += m_bits[k][i] * (1 << i);
                        case (int'(cpu_a))
                            0:       m_ctrl[k] = w;
                            1:       m_chr0[k] = w;
                            2:       m_chr1[k] = w;
                            default: m_prg[k]  = w;
                        endcase
                        m_bits[k].delete();
                    end
                end
            end
        end
    endtask

    // One bus cycle: drive, compare every instance against the model, clock.
    task automatic applyStimulus(input bit wr, input int a, input bit d7, input bit d0,
                                 input bit a14, input bit sel, input int ppu);
        cpu_wr       = wr;
        cpu_a        = 2'(a);
        cpu_d7       = d7;
        cpu_d0       = d0;
        cpu_a14      = a14;
        cpu_wram_sel = sel;
        ppu_a        = 3'(ppu);
        #3;
        model_check_all();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    // Serial write LSB first with a gap after each strobe; only the final
    // strobe carries the real target address.
    task automatic serial_bits(input int addr, input int value, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            int a;
            a = (i == nbits - 1) ? addr : int'($urandom_range(0, 3));
            applyStimulus(1'b1, a, 1'b0, 1'((value >> i) & 1), 1'b0, 1'b0, 0);
            idle();
        end
    endtask

    task automatic pulse_nres();
        nres = 1'b0;
        model_reset();
        #2;
        nres = 1'b1;
    endtask

    task automatic set_view(input int a14, input int sel, input int ppu);
        cpu_wr       = 1'b0;
        cpu_d7       = 1'b0;
        cpu_a14      = 1'(a14);
        cpu_wram_sel = 1'(sel);
        ppu_a        = 3'(ppu);
        #2;
    endtask

    initial begin
        cpu_wr = 1'b0;  cpu_a = 2'd0;  cpu_d7 = 1'b0;  cpu_d0 = 1'b0;
        cpu_a14 = 1'b0;  cpu_wram_sel = 1'b0;  ppu_a = 3'd0;
        nres = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        nres = 1'b1;

        // Directed operations for dut0 with fixed expectations:
        //           a14 sel ppu   prg chr ciram ce busy
        vecs.push_back(chk(0, 0, 0,    0,  0, 0, 1, 0));
        vecs.push_back(chk(1, 1, 4,   15,  1, 0, 0, 0));
        vecs.push_back(chk(0, 1, 2,    0,  0, 0, 0, 0));
        // 0x0A: PRG mode 2, vertical mirroring; then PRG bank 5.
        vecs.push_back(mk(OP_WRITE, 0, 'h0A, 5, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(OP_WRITE, 3, 'h05, 5, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(chk(0, 0, 1,    0,  0, 1, 1, 0));
        vecs.push_back(chk(1, 1, 0,    5,  0, 0, 0, 0));
        vecs.push_back(chk(1, 0, 2,    5,  0, 0, 1, 0));
        // 4 KiB CHR mode with distinct banks, PRG in 32 KiB mode.
        vecs.push_back(mk(OP_WRITE, 0, 'h10, 5, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(OP_WRITE, 1, 'h03, 5, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(OP_WRITE, 2, 'h1A, 5, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(chk(0, 0, 0,    4,  3, 0, 1, 0));
        vecs.push_back(chk(1, 0, 4,    5, 26, 0, 1, 0));
        vecs.push_back(mk(OP_WRITE, 0, 'h00, 5, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(chk(0, 0, 0,    4,  2, 0, 1, 0));
        vecs.push_back(chk(1, 0, 4,    5,  3, 0, 1, 0));
        // Three bits, then a d7 reset write.
        vecs.push_back(mk(OP_PARTIAL, 0, 'h07, 3, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(chk(0, 0, 0,    4,  2, 0, 1, 1));
        vecs.push_back(mk(OP_RESETWR, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(chk(0, 0, 0,    5,  2, 0, 1, 0));
        vecs.push_back(chk(1, 1, 4,   15,  3, 0, 0, 0));
        // d7 reset arriving on the final bit: nothing commits.
        vecs.push_back(mk(OP_PARTIAL, 3, 'h1F, 4, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(chk(0, 0, 0,    5,  2, 0, 1, 1));
        vecs.push_back(mk(OP_RESETWR, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(chk(0, 0, 0,    5,  2, 0, 1, 0));
        // Single-screen high, then horizontal mirroring.
        vecs.push_back(mk(OP_WRITE, 0, 'h0D, 5, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(chk(0, 0, 0,    5,  2, 1, 1, 0));
        vecs.push_back(mk(OP_WRITE, 0, 'h0F, 5, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(chk(0, 0, 2,    5,  2, 1, 1, 0));
        vecs.push_back(chk(0, 0, 1,    5,  2, 0, 1, 0));
        // Partial word, then nres mid-sequence.
        vecs.push_back(mk(OP_PARTIAL, 1, 'h05, 3, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(OP_NRES, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(chk(0, 0, 0,    0,  0, 0, 1, 0));
        vecs.push_back(chk(1, 1, 4,   15,  1, 0, 0, 0));

        foreach (vecs[i]) begin
            case (vecs[i].op)
                OP_WRITE, OP_PARTIAL: serial_bits(vecs[i].addr, vecs[i].value, vecs[i].nbits);
                OP_RESETWR: begin
                    applyStimulus(1'b1, int'($urandom_range(0, 3)), 1'b1, 1'b0, 1'b0, 1'b0, 0);
                    idle();
                end
                OP_NRES: pulse_nres();
                default: begin
                    set_view(vecs[i].a14, vecs[i].sel, vecs[i].ppu);
                    checkOutput($sformatf("vec%0d prg_bank", i), int'(o_prg[0]), vecs[i].e_prg);
                    checkOutput($sformatf("vec%0d chr_bank", i), int'(o_chr[0]), vecs[i].e_chr);
                    checkOutput($sformatf("vec%0d ciram_a10", i), int'(o_ciram[0]),
                                vecs[i].e_ciram);
                    checkOutput($sformatf("vec%0d wram_ce_n", i), int'(o_ce[0]), vecs[i].e_ce);
                    checkOutput($sformatf("vec%0d shift_busy", i), int'(o_busy[0]),
                                vecs[i].e_busy);
                    applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'(vecs[i].a14), 1'(vecs[i].sel),
                                  vecs[i].ppu);
                end
            endcase
        end

        // Back-to-back strobes: dut0 takes one bit, dut1 takes both. Four
        // more bits complete dut0's word and leave dut1 one bit into the next.
        pulse_nres();
        applyStimulus(1'b1, 3, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        applyStimulus(1'b1, 3, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        idle();
        serial_bits(3, 'hF, 4);
        set_view(0, 1, 0);
        checkOutput("rmw dut0 shift_busy", int'(o_busy[0]), 0);
        checkOutput("rmw dut1 shift_busy", int'(o_busy[1]), 1);
        checkOutput("rmw dut0 prg_bank", int'(o_prg[0]), 15);
        checkOutput("rmw dut0 wram_ce_n", int'(o_ce[0]), 1);
        idle();

        // 6-bit words: PRG bit 5 disables WRAM, clearing it re-enables.
        pulse_nres();
        serial_bits(3, 'h20, 6);
        set_view(0, 1, 0);
        checkOutput("w6 prg20 wram_ce_n", int'(o_ce[2]), 1);
        checkOutput("w6 prg20 prg_bank", int'(o_prg[2]), 0);
        idle();
        serial_bits(3, 'h00, 6);
        set_view(0, 1, 0);
        checkOutput("w6 prg00 wram_ce_n", int'(o_ce[2]), 0);
        idle();

        // Random traffic against the model, with occasional async resets.
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 99) == 0) pulse_nres();
            applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                          ($urandom_range(0, 11) == 0), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          int'($urandom_range(0, 7)));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
